// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline.
// Produces stall/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB,
// freezes the whole pipe while data memory is busy, latches a sticky halt
// when memory stays busy too long, and keeps saturating event counters.
module hazard_ctrl #(
  parameter int MAX_MEM_WAIT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       instructionRsID,
  input  logic [4:0]       instructionRtID,
  input  logic             usesRsID,
  input  logic             usesRtID,
  input  logic             branchID,
  input  logic             branchTakenID,
  input  logic             regWriteEX,
  input  logic             memReadEX,
  input  logic [4:0]       writeRegEX,
  input  logic             memReadMEM,
  input  logic [4:0]       writeRegMEM,
  input  logic             dmemBusy,
  output logic             pcWrite,
  output logic             ifIdStall,
  output logic             ifIdFlush,
  output logic             idExStall,
  output logic             idExFlush,
  output logic             exMemStall,
  output logic             memWbFlush,
  output logic             halted,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int WCNT_W = (MAX_MEM_WAIT > 1) ? $clog2(MAX_MEM_WAIT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_MEM_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic m_ex, m_mem;
  logic load_use, br_ex, br_ld, data_haz, freeze;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // ID source-operand match against a producer; register 0 never matches.
  assign m_ex  = (usesRsID && (writeRegEX  != 5'd0) && (instructionRsID == writeRegEX)) ||
                 (usesRtID && (writeRegEX  != 5'd0) && (instructionRtID == writeRegEX));
  assign m_mem = (usesRsID && (writeRegMEM != 5'd0) && (instructionRsID == writeRegMEM)) ||
                 (usesRtID && (writeRegMEM != 5'd0) && (instructionRtID == writeRegMEM));

  assign load_use = memReadEX && m_ex;
  assign br_ex    = branchID && regWriteEX && m_ex;
  assign br_ld    = branchID && memReadMEM && m_mem;
  assign data_haz = load_use || br_ex || br_ld;
  assign freeze   = dmemBusy || (state_q == HALT);

  // Pipeline controls by priority: reset, freeze, data hazard, redirect.
  always_comb begin
    pcWrite    = 1'b0;
    ifIdStall  = 1'b0;
    ifIdFlush  = 1'b0;
    idExStall  = 1'b0;
    idExFlush  = 1'b0;
    exMemStall = 1'b0;
    memWbFlush = 1'b0;
    if (rst) begin
      pcWrite = 1'b0;
    end else if (freeze) begin
      ifIdStall  = 1'b1;
      idExStall  = 1'b1;
      exMemStall = 1'b1;
      memWbFlush = 1'b1;
    end else if (data_haz) begin
      ifIdStall = 1'b1;
      idExFlush = 1'b1;
    end else if (branchTakenID) begin
      pcWrite   = 1'b1;
      ifIdFlush = 1'b1;
    end else begin
      pcWrite = 1'b1;
    end
  end

  // Memory-wait timeout FSM: counts consecutive busy edges, halts on the limit.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (dmemBusy) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (!dmemBusy) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      HALT:    state_d = HALT;
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Next values of the saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze || data_haz) stall_cnt_d = sat_inc(stall_cnt_q);
    if (ifIdFlush)          flush_cnt_d = sat_inc(flush_cnt_q);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted      = (state_q == HALT);
  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    instructionRsID, instructionRtID;
  logic          usesRsID, usesRtID, branchID, branchTakenID;
  logic          regWriteEX, memReadEX;
  logic [4:0]    writeRegEX;
  logic          memReadMEM;
  logic [4:0]    writeRegMEM;
  logic          dmemBusy;
  logic          pcWrite, ifIdStall, ifIdFlush, idExStall, idExFlush;
  logic          exMemStall, memWbFlush, halted;
  logic [CW-1:0] stallCycles, flushCount;

  int tests = 0;
  int fails = 0;

  // reference model state
  int busy_run;
  bit m_halted;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_MEM_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .instructionRsID(instructionRsID), .instructionRtID(instructionRtID),
    .usesRsID(usesRsID), .usesRtID(usesRtID),
    .branchID(branchID), .branchTakenID(branchTakenID),
    .regWriteEX(regWriteEX), .memReadEX(memReadEX), .writeRegEX(writeRegEX),
    .memReadMEM(memReadMEM), .writeRegMEM(writeRegMEM), .dmemBusy(dmemBusy),
    .pcWrite(pcWrite), .ifIdStall(ifIdStall), .ifIdFlush(ifIdFlush),
    .idExStall(idExStall), .idExFlush(idExFlush), .exMemStall(exMemStall),
    .memWbFlush(memWbFlush), .halted(halted),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  function automatic bit reads(input logic [4:0] r);
    return (usesRsID && r != 0 && instructionRsID == r) ||
           (usesRtID && r != 0 && instructionRtID == r);
  endfunction

  function automatic bit model_haz();
    return (memReadEX && reads(writeRegEX)) ||
           (branchID && regWriteEX && reads(writeRegEX)) ||
           (branchID && memReadMEM && reads(writeRegMEM));
  endfunction

  // {pcWrite, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbFlush, halted}
  function automatic logic [7:0] model_outs();
    logic [6:0] c;
    if (rst)                        c = 7'b0000000;
    else if (dmemBusy || m_halted)  c = 7'b0101011;
    else if (model_haz())           c = 7'b0100100;
    else if (branchTakenID)         c = 7'b1010000;
    else                            c = 7'b1000000;
    return {c, m_halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit frz, haz;
    if (rst) begin
      busy_run = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    end else begin
      frz = dmemBusy || m_halted;
      haz = model_haz();
      if ((frz || haz) && m_stall < CMAX) m_stall++;
      if (!frz && !haz && branchTakenID && m_flush < CMAX) m_flush++;
      if (!m_halted) begin
        if (dmemBusy) begin
          busy_run++;
          if (busy_run >= MAXW) m_halted = 1;
        end else begin
          busy_run = 0;
        end
      end
    end
  endtask

  // one clock: check outputs mid-cycle, advance model at the edge
  task automatic step(input string tag);
    @(negedge clk);
    check({tag, ".ctrl"}, 32'({pcWrite, ifIdStall, ifIdFlush, idExStall,
                               idExFlush, exMemStall, memWbFlush, halted}),
          32'(model_outs()));
    check({tag, ".stall"}, 32'(stallCycles), 32'(m_stall));
    check({tag, ".flush"}, 32'(flushCount), 32'(m_flush));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    instructionRsID = 0; instructionRtID = 0; usesRsID = 0; usesRtID = 0;
    branchID = 0; branchTakenID = 0; regWriteEX = 0; memReadEX = 0;
    writeRegEX = 0; memReadMEM = 0; writeRegMEM = 0; dmemBusy = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    busy_run = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("reset.halted", 32'(halted), 32'd0);
    check("reset.stallCycles", 32'(stallCycles), 32'd0);

    // load-use on rs
    memReadEX = 1; regWriteEX = 1; writeRegEX = 8; usesRsID = 1; instructionRsID = 8;
    step("lu.stall");
    memReadEX = 0; regWriteEX = 0; writeRegEX = 0;
    step("lu.resume");
    check("lu.stallCycles", 32'(stallCycles), 32'd1);

    // register 0 never creates a dependency
    do_reset();
    memReadEX = 1; writeRegEX = 0; usesRsID = 1; instructionRsID = 0;
    step("r0.nostall");
    check("r0.pcWrite", 32'(pcWrite), 32'd1);
    check("r0.stallCycles", 32'(stallCycles), 32'd0);

    // load followed by dependent beq: two stalls then redirect
    do_reset();
    branchID = 1; usesRsID = 1; instructionRsID = 9;
    memReadEX = 1; regWriteEX = 1; writeRegEX = 9;
    step("ldbr.ex");
    memReadEX = 0; regWriteEX = 0; writeRegEX = 0; memReadMEM = 1; writeRegMEM = 9;
    step("ldbr.mem");
    memReadMEM = 0; writeRegMEM = 0; branchTakenID = 1;
    step("ldbr.taken");
    clear_inputs();
    step("ldbr.after");
    check("ldbr.stallCycles", 32'(stallCycles), 32'd2);
    check("ldbr.flushCount", 32'(flushCount), 32'd1);

    // ALU producer on rt feeding a branch: one stall
    do_reset();
    branchID = 1; usesRtID = 1; instructionRtID = 5; regWriteEX = 1; writeRegEX = 5;
    branchTakenID = 1;
    step("alubr.stall");
    regWriteEX = 0; writeRegEX = 0;
    step("alubr.taken");
    check("alubr.stallCycles", 32'(stallCycles), 32'd1);

    // freeze beats a taken branch, then the flush happens
    do_reset();
    branchTakenID = 1; dmemBusy = 1;
    repeat (3) step("frz.busy");
    check("frz.halted", 32'(halted), 32'd0);
    check("frz.flushCount", 32'(flushCount), 32'd0);
    dmemBusy = 0;
    step("frz.flush");
    check("frz.flushAfter", 32'(flushCount), 32'd1);
    check("frz.stallCycles", 32'(stallCycles), 32'd3);

    // timeout: MAXW busy edges halt; stays frozen afterwards
    do_reset();
    dmemBusy = 1;
    repeat (MAXW) step("to.busy");
    check("to.halted", 32'(halted), 32'd1);
    dmemBusy = 0; branchTakenID = 1;
    repeat (3) step("to.frozen");
    check("to.pcWrite", 32'(pcWrite), 32'd0);

    // stall counter saturates while halted
    clear_inputs();
    repeat (CMAX + 5) step("sat.stall");
    check("sat.stallCycles", 32'(stallCycles), 32'(CMAX));

    // reset from HALT
    do_reset();
    check("rsthalt.halted", 32'(halted), 32'd0);
    check("rsthalt.counters", 32'({stallCycles, flushCount}), 32'd0);

    // reset mid-MEM_WAIT restarts the wait count
    dmemBusy = 1;
    repeat (MAXW - 1) step("rstmw.busy");
    rst = 1;
    step("rstmw.rst");
    rst = 0;
    repeat (MAXW - 1) step("rstmw.busy2");
    check("rstmw.halted", 32'(halted), 32'd0);
    dmemBusy = 0;
    step("rstmw.run");
    check("rstmw.pcWrite", 32'(pcWrite), 32'd1);

    // flush counter saturates
    do_reset();
    branchTakenID = 1;
    repeat (CMAX + 5) step("sat.flush");
    check("sat.flushCount", 32'(flushCount), 32'(CMAX));

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      instructionRsID = 5'($urandom_range(0, 3));
      instructionRtID = 5'($urandom_range(0, 3));
      usesRsID        = 1'($urandom);
      usesRtID        = 1'($urandom);
      branchID        = 1'($urandom);
      branchTakenID   = 1'($urandom);
      regWriteEX      = 1'($urandom);
      memReadEX       = 1'($urandom);
      writeRegEX      = 5'($urandom_range(0, 3));
      memReadMEM      = 1'($urandom);
      writeRegMEM     = 5'($urandom_range(0, 3));
      dmemBusy        = ($urandom_range(0, 2) == 0);
      rst             = ($urandom_range(0, 39) == 0);
      step("rand");
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
